// File: rtl/qspi_seq_engine.sv
// qspi_seq_engine: bit-level QSPI transaction sequencer.
// Accepts one decoded command per handshake. It then runs
// CS_SETUP -> CMD -> [ADDR] -> [DUMMY] -> [DATA] -> CS_HOLD -> CS_HIGH -> DONE
// and returns up to 32 bits of read data.
// Ports:
//   CLK, RSTb                  clock, async active-low reset
//   cmd_*                      command request/handshake and decoded fields
//   rsp_valid, rsp_rd_data     one-cycle completion pulse and read word
//   busy                       high from accept until rsp_valid
//   qspi_sclk_ddr, qspi_CSb    DDR SCLK pattern and chip select
//   qspi_dN_ddr_out/in         per-line DDR pad data (N = 0..3)
//   qspi_io_dir                pad direction, 1 = output, bit n = dn
module qspi_seq_engine #(
    parameter int unsigned CS_HIGH_MIN = 2,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic        cmd_has_addr,
    input  logic [23:0] cmd_addr,
    input  logic        cmd_quad_addr,
    input  logic [3:0]  cmd_dummy,
    input  logic [2:0]  cmd_nbytes,
    input  logic        cmd_write,
    input  logic        cmd_quad_data,
    input  logic [31:0] cmd_wr_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_rd_data,
    output logic        busy,
    output logic [1:0]  qspi_sclk_ddr,
    output logic        qspi_CSb,
    output logic [1:0]  qspi_d0_ddr_out,
    output logic [1:0]  qspi_d1_ddr_out,
    output logic [1:0]  qspi_d2_ddr_out,
    output logic [1:0]  qspi_d3_ddr_out,
    input  logic [1:0]  qspi_d0_ddr_in,
    input  logic [1:0]  qspi_d1_ddr_in,
    input  logic [1:0]  qspi_d2_ddr_in,
    input  logic [1:0]  qspi_d3_ddr_in,
    output logic [3:0]  qspi_io_dir
);

    localparam int unsigned CNT_W = 6;
    localparam logic [1:0]  LAT_SEL = 2'(RD_LATENCY);
    // Pipeline stages whose capture still lies in the future; DONE waits on them.
    localparam logic [2:0]  PEND_MASK = (RD_LATENCY <= 1) ? 3'b000 :
                                        3'((32'd1 << (RD_LATENCY - 1)) - 32'd1);

    typedef struct packed {
        logic [7:0]  opcode;
        logic        has_addr;
        logic [23:0] addr;
        logic        quad_addr;
        logic [3:0]  dummy;
        logic [2:0]  nbytes;
        logic        write;
        logic        quad_data;
        logic [31:0] wr_data;
    } cmd_t;

    typedef enum logic [3:0] {
        S_IDLE, S_CS_SETUP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_CS_HOLD, S_CS_HIGH, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    cmd_t               cmd_q, cmd_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic [2:0]         pipe_q;
    logic               cmd_ready_q, busy_q, rsp_valid_q;
    logic               csb_q, csb_d;
    logic [1:0]         sclk_q, sclk_d;
    logic [3:0]         dir_q, dir_d;
    logic [3:0]         dout_q, dout_d;     // {d3, d2, d1, d0}

    logic [2:0]         nb;
    logic               rd_pulse;
    logic [3:0]         tap;
    logic               cap_now;
    logic [3:0]         nib_in;
    logic [23:0]        addr_sh;
    logic [31:0]        wr_sh;
    logic               unused_in;

    // Byte count saturates at 4; read-pulse delay line selects the capture cycle.
    assign nb       = (cmd_q.nbytes > 3'd4) ? 3'd4 : cmd_q.nbytes;
    assign rd_pulse = (state_q == S_DATA) && !cmd_q.write;
    assign tap      = {pipe_q, rd_pulse};
    assign cap_now  = tap[LAT_SEL];
    assign nib_in   = {qspi_d3_ddr_in[1], qspi_d2_ddr_in[1], qspi_d1_ddr_in[1], qspi_d0_ddr_in[1]};
    assign unused_in = ^{qspi_d0_ddr_in[0], qspi_d1_ddr_in[0], qspi_d2_ddr_in[0], qspi_d3_ddr_in[0]};

    // Next-state, phase counter, command latch and read capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        rd_data_d = rd_data_q;
        if (cap_now) begin
            rd_data_d = cmd_q.quad_data ? {rd_data_q[27:0], nib_in}
                                        : {rd_data_q[30:0], qspi_d1_ddr_in[1]};
        end
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d   = S_CS_SETUP;
                    rd_data_d = '0;
                    cmd_d     = '{opcode: cmd_opcode, has_addr: cmd_has_addr, addr: cmd_addr,
                                  quad_addr: cmd_quad_addr, dummy: cmd_dummy, nbytes: cmd_nbytes,
                                  write: cmd_write, quad_data: cmd_quad_data, wr_data: cmd_wr_data};
                end
            end
            S_CS_SETUP: begin
                state_d = S_CMD;
                cnt_d   = 6'd7;
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 6'd1;
                end else if (state_q == S_CMD && cmd_q.has_addr) begin
                    state_d = S_ADDR;
                    cnt_d   = cmd_q.quad_addr ? 6'd5 : 6'd23;
                end else if ((state_q inside {S_CMD, S_ADDR}) && cmd_q.dummy != 4'd0) begin
                    state_d = S_DUMMY;
                    cnt_d   = CNT_W'(cmd_q.dummy) - 6'd1;
                end else if (state_q != S_DATA && nb != 3'd0) begin
                    state_d = S_DATA;
                    cnt_d   = cmd_q.quad_data ? CNT_W'({nb, 1'b0}) - 6'd1
                                              : CNT_W'({nb, 3'b000}) - 6'd1;
                end else begin
                    state_d = S_CS_HOLD;
                end
            end
            S_CS_HOLD: begin
                state_d = S_CS_HIGH;
                cnt_d   = CNT_W'(CS_HIGH_MIN - 1);
            end
            S_CS_HIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 6'd1;
                end else if ((pipe_q & PEND_MASK) == 3'b000) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pad drive for the upcoming cycle, decoded from the next state so pads are registered.
    always_comb begin
        csb_d   = 1'b1;
        sclk_d  = 2'b00;
        dir_d   = 4'b1101;
        dout_d  = 4'b1100;
        addr_sh = cmd_d.addr >> cnt_d;
        wr_sh   = cmd_d.wr_data >> cnt_d;
        case (state_d)
            S_CS_SETUP, S_CS_HOLD: csb_d = 1'b0;
            S_CMD: begin
                csb_d     = 1'b0;
                sclk_d    = 2'b10;
                dout_d[0] = cmd_d.opcode[cnt_d[2:0]];
            end
            S_ADDR: begin
                csb_d  = 1'b0;
                sclk_d = 2'b10;
                if (cmd_d.quad_addr) begin
                    dir_d  = 4'b1111;
                    dout_d = 4'(cmd_d.addr >> {cnt_d, 2'b00});
                end else begin
                    dout_d[0] = addr_sh[0];
                end
            end
            S_DUMMY: begin
                csb_d  = 1'b0;
                sclk_d = 2'b10;
                // Release the bus early so the flash can turn it around for quad reads.
                if (cmd_d.quad_data && !cmd_d.write) dir_d = 4'b0000;
            end
            S_DATA: begin
                csb_d  = 1'b0;
                sclk_d = 2'b10;
                if (cmd_d.quad_data) begin
                    if (cmd_d.write) begin
                        dir_d  = 4'b1111;
                        dout_d = 4'(cmd_d.wr_data >> {cnt_d, 2'b00});
                    end else begin
                        dir_d  = 4'b0000;
                    end
                end else if (cmd_d.write) begin
                    dout_d[0] = wr_sh[0];
                end
            end
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            rd_data_q   <= '0;
            pipe_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            csb_q       <= 1'b1;
            sclk_q      <= 2'b00;
            dir_q       <= 4'b1101;
            dout_q      <= 4'b1100;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            rd_data_q   <= rd_data_d;
            pipe_q      <= tap[2:0];
            cmd_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            rsp_valid_q <= (state_d == S_DONE);
            csb_q       <= csb_d;
            sclk_q      <= sclk_d;
            dir_q       <= dir_d;
            dout_q      <= dout_d;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign busy            = busy_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rd_data     = rd_data_q;
    assign qspi_CSb        = csb_q;
    assign qspi_sclk_ddr   = sclk_q;
    assign qspi_io_dir     = dir_q;
    assign qspi_d0_ddr_out = {2{dout_q[0]}};
    assign qspi_d1_ddr_out = {2{dout_q[1]}};
    assign qspi_d2_ddr_out = {2{dout_q[2]}};
    assign qspi_d3_ddr_out = {2{dout_q[3]}};

endmodule
